// File: rtl/cpu_mc_pkg.sv
// Shared types and decode/ALU helpers for the multi-cycle RV32I-subset core.
// Pure combinational functions; no state and no flow control of their own.
package cpu_mc_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

   typedef struct packed {
      logic    legal;
      alu_op_t alu_op;
      imm_t    imm_sel;
      wb_sel_t wb_sel;
      logic    wr_en;
      logic    use_rs1;
      logic    use_rs2;
      logic    a_zero;
      logic    a_pc;
      logic    rs2_op;
      logic    br;
      logic    jal;
      logic    jalr;
      logic    ld;
      logic    st;
   } dec_t;

   function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // SYSTEM (ECALL/EBREAK) and every unlisted opcode leave legal=0, so both halt.
   function automatic dec_t decode(input logic [31:0] ir);
      dec_t       d;
      logic [2:0] f3;
      logic [6:0] f7;
      f3        = ir[14:12];
      f7        = ir[31:25];
      d         = '0;
      d.alu_op  = ALU_ADD;
      d.imm_sel = IMM_I;
      d.wb_sel  = WB_ALU;
      case (ir[6:0])
         LUI:    begin d.legal = 1'b1; d.wr_en = 1'b1; d.a_zero = 1'b1; d.imm_sel = IMM_U; end
         AUIPC:  begin d.legal = 1'b1; d.wr_en = 1'b1; d.a_pc = 1'b1; d.imm_sel = IMM_U; end
         JAL:    begin d.legal = 1'b1; d.wr_en = 1'b1; d.jal = 1'b1; d.imm_sel = IMM_J; d.wb_sel = WB_PC4; end
         JALR:   begin
            d.legal = (f3 == 3'b000); d.wr_en = 1'b1; d.jalr = 1'b1;
            d.use_rs1 = 1'b1; d.wb_sel = WB_PC4;
         end
         BRANCH: begin
            d.legal = (f3[2:1] != 2'b01); d.br = 1'b1;
            d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.imm_sel = IMM_B;
         end
         LOAD:   begin
            d.legal = (f3 == 3'b010); d.ld = 1'b1; d.wr_en = 1'b1;
            d.use_rs1 = 1'b1; d.wb_sel = WB_MEM;
         end
         STORE:  begin
            d.legal = (f3 == 3'b010); d.st = 1'b1;
            d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.imm_sel = IMM_S;
         end
         OP_IMM: begin
            d.legal = (f3 == 3'b001) ? (f7 == 7'b0) :
                      (f3 == 3'b101) ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
            d.wr_en = 1'b1; d.use_rs1 = 1'b1;
            d.alu_op = alu_sel(f3, f7[5] && f3 == 3'b101);
         end
         OP:     begin
            d.legal = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            d.wr_en = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.rs2_op = 1'b1;
            d.alu_op = alu_sel(f3, f7[5]);
         end
         default: ;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_t sel);
      case (sel)
         IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
         IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         IMM_U:   return {ir[31:12], 12'b0};
         IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default: return {{20{ir[31]}}, ir[31:20]};
      endcase
   endfunction

   function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'b0, a < b};
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return a + b;
      endcase
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_mc_if.sv
// Shared instruction/data memory port: req held until ack, any number of wait cycles.
interface cpu_mc_if #(parameter int XLEN = 32);
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
   modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cpu_mc_regfile.sv
// NREGS x XLEN register file, two combinational reads, one clocked write, x0 reads 0.
// Indices at or above NREGS read 0 and are never written.
module cpu_mc_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we_i,
   input  logic [4:0]      waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [4:0]      raddr1_i,
   output logic [XLEN-1:0] rdata1_o,
   input  logic [4:0]      raddr2_i,
   output logic [XLEN-1:0] rdata2_o
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] regs_q [NREGS];

   function automatic logic hit(input logic [4:0] a);
      return (a != 5'd0) && ({1'b0, a} < 6'(NREGS));
   endfunction

   assign rdata1_o = hit(raddr1_i) ? regs_q[raddr1_i[AW-1:0]] : '0;
   assign rdata2_o = hit(raddr2_i) ? regs_q[raddr2_i[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i && hit(waddr_i)) begin
         regs_q[waddr_i[AW-1:0]] <= wdata_i;
      end
   end
endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/[MEM]/WB, 4 cycles (5 for LW/SW) plus memory waits.
// Stalls in FETCH/MEM until mem_ack; halts permanently on illegal, misaligned, ECALL or EBREAK.
module cpu_mc
   import cpu_mc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   cpu_mc_if.master        bus,
   output logic [XLEN-1:0] pc_o,
   output logic            retire,
   output logic            halted
);
   state_t          state_q, state_d;
   logic            run_q;
   logic [XLEN-1:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
   logic [XLEN-1:0] alu_q, alu_d, npc_q, npc_d, mdr_q, mdr_d;

   dec_t            dec;
   logic [4:0]      rd, rs1, rs2;
   logic            bad_idx, redirect;
   logic [XLEN-1:0] rf_rd1, rf_rd2, rf_wdata, alu_res, jmp_tgt;
   logic            rf_we;

   assign dec = decode(ir_q);
   assign rd  = ir_q[11:7];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   // Only fields the instruction actually uses are range-checked; others hold immediate bits.
   assign bad_idx = (dec.use_rs1 && {1'b0, rs1} >= 6'(NREGS)) ||
                    (dec.use_rs2 && {1'b0, rs2} >= 6'(NREGS)) ||
                    (dec.wr_en   && {1'b0, rd}  >= 6'(NREGS));

   assign alu_res  = alu(dec.alu_op, a_q, dec.rs2_op ? b_q : imm_q);
   assign jmp_tgt  = dec.jalr ? (alu_res & ~XLEN'(1)) : pc_q + imm_q;
   assign redirect = dec.jal || dec.jalr || (dec.br && br_taken(ir_q[14:12], a_q, b_q));

   always_comb begin
      rf_wdata = alu_q;
      case (dec.wb_sel)
         WB_MEM:  rf_wdata = mdr_q;
         WB_PC4:  rf_wdata = pc_q + XLEN'(4);
         default: ;
      endcase
   end

   cpu_mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .we_i     (rf_we),
      .waddr_i  (rd),
      .wdata_i  (rf_wdata),
      .raddr1_i (rs1),
      .rdata1_o (rf_rd1),
      .raddr2_i (rs2),
      .rdata2_o (rf_rd2)
   );

   // run_q holds off the first fetch one cycle so an ack straddling reset release is never taken.
   always_comb begin
      state_d = state_q;
      pc_d = pc_q;  ir_d = ir_q;  a_d = a_q;  b_d = b_q;  imm_d = imm_q;
      alu_d = alu_q;  npc_d = npc_q;  mdr_d = mdr_q;
      bus.mem_req = 1'b0;  bus.mem_we = 1'b0;  bus.mem_addr = '0;  bus.mem_wdata = '0;
      retire = 1'b0;
      rf_we  = 1'b0;
      case (state_q)
         FETCH: if (run_q) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc_q;
            if (bus.mem_ack) begin
               ir_d    = bus.mem_rdata;
               state_d = DECODE;
            end
         end
         DECODE: begin
            a_d     = dec.a_zero ? '0 : dec.a_pc ? pc_q : rf_rd1;
            b_d     = rf_rd2;
            imm_d   = imm_gen(ir_q, dec.imm_sel);
            state_d = (!dec.legal || bad_idx) ? HALT : EXEC;
         end
         EXEC: begin
            alu_d = alu_res;
            npc_d = redirect ? jmp_tgt : pc_q + XLEN'(4);
            if (redirect && jmp_tgt[1])  state_d = HALT;
            else if (dec.ld || dec.st)   state_d = MEM;
            else                         state_d = WB;
         end
         MEM: begin
            if (alu_q[1:0] != 2'b00) begin
               state_d = HALT;
            end else begin
               bus.mem_req   = 1'b1;
               bus.mem_we    = dec.st;
               bus.mem_addr  = {alu_q[XLEN-1:2], 2'b00};
               bus.mem_wdata = b_q;
               if (bus.mem_ack) begin
                  if (dec.ld) mdr_d = bus.mem_rdata;
                  state_d = WB;
               end
            end
         end
         WB: begin
            rf_we   = dec.wr_en;
            pc_d    = npc_q;
            retire  = 1'b1;
            state_d = FETCH;
         end
         HALT:    ;
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
         run_q   <= 1'b0;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         npc_q   <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         alu_q   <= alu_d;
         npc_q   <= npc_d;
         mdr_q   <= mdr_d;
      end
   end

   assign pc_o   = pc_q;
   assign halted = (state_q == HALT);
endmodule

// File: tb/tb_cpu_mc.sv
// Directed program bench for cpu_mc (NREGS=32) plus a second NREGS=16 instance.
module tb_cpu_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   always #5 clk = ~clk;

   cpu_mc_if mif ();
   cpu_mc_if mif16 ();

   logic [31:0] pc, pc16;
   logic        retire, halted, retire16, halted16;

   cpu_mc dut (
      .clk(clk), .rst(rst), .bus(mif), .pc_o(pc), .retire(retire), .halted(halted)
   );

   cpu_mc #(.NREGS(16)) dut16 (
      .clk(clk), .rst(rst), .bus(mif16), .pc_o(pc16), .retire(retire16), .halted(halted16)
   );

   // Memory model: 0x00-0x3C program words, 0x40-0x7C data words.
   logic [31:0] prog [16];
   logic [31:0] dmem [16];
   int          wait_n = 0;
   int          wcnt = 0;
   logic        stale_ack = 1'b0;

   always_comb begin
      mif.mem_ack   = (mif.mem_req && wcnt == wait_n) || stale_ack;
      mif.mem_rdata = mif.mem_addr[6] ? dmem[mif.mem_addr[5:2]] : prog[mif.mem_addr[5:2]];
   end

   always @(posedge clk) begin
      if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 1;
      else                             wcnt <= 0;
      if (mif.mem_req && mif.mem_ack && mif.mem_we && mif.mem_addr[6])
         dmem[mif.mem_addr[5:2]] <= mif.mem_wdata;
   end

   // The NREGS=16 core only ever sees addi x20,x0,1.
   assign mif16.mem_ack   = mif16.mem_req;
   assign mif16.mem_rdata = 32'h00100A13;

   int ret_cnt = 0;
   int ret16_cnt = 0;
   always @(posedge clk) begin
      if (retire)   ret_cnt   <= ret_cnt + 1;
      if (retire16) ret16_cnt <= ret16_cnt + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic wait_retire(input string tag, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!retire && n < budget);
      chk(tag, {31'b0, retire}, 32'd1);
   endtask

   task automatic wait_halt(input string tag, input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'b0, halted}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt, r0;
      prog[0]  = 32'h00500093;  // addi x1,x0,5
      prog[1]  = 32'hFF908113;  // addi x2,x1,-7
      prog[2]  = 32'h04202023;  // sw   x2,0x40(x0)
      prog[3]  = 32'h04002183;  // lw   x3,0x40(x0)
      prog[4]  = 32'h00114463;  // blt  x2,x1,+8
      prog[5]  = 32'h06300393;  // addi x7,x0,99 (skipped)
      prog[6]  = 32'h00116463;  // bltu x2,x1,+8 (not taken)
      prog[7]  = 32'h00100013;  // addi x0,x0,1
      prog[8]  = 32'h010002EF;  // jal  x5,+16
      for (int i = 9; i < 12; i++) prog[i] = 32'h00000013;
      prog[12] = 32'hABCDE337;  // lui  x6,0xABCDE
      prog[13] = 32'h00000000;  // illegal opcode
      prog[14] = 32'h0;
      prog[15] = 32'h0;

      repeat (2) @(negedge clk);
      chk("rst_req",    {31'b0, mif.mem_req}, 32'd0);
      chk("rst_we",     {31'b0, mif.mem_we}, 32'd0);
      chk("rst_addr",   mif.mem_addr, 32'd0);
      chk("rst_wdata",  mif.mem_wdata, 32'd0);
      chk("rst_retire", {31'b0, retire}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_pc",     pc, 32'd0);
      rst = 1'b1;

      wait_retire("addi1_retire", 20, n);
      wait_retire("addi2_retire", 20, n);
      chk("alu_latency", n, 32'd4);
      wait_n = 3;
      @(negedge clk);
      chk("pc_after_addi", pc, 32'h8);
      chk("x2_addi_neg", dut.u_rf.regs_q[2], 32'hFFFF_FFFE);

      cnt = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (mif.mem_req && mif.mem_we && mif.mem_addr == 32'h40 && mif.mem_wdata == 32'hFFFF_FFFE)
            cnt++;
      end while (!retire && n < 60);
      chk("sw_retire", {31'b0, retire}, 32'd1);
      chk("sw_hold_cycles", cnt, 32'd4);
      chk("sw_data", dmem[0], 32'hFFFF_FFFE);

      wait_retire("lw_retire", 40, n);
      chk("lw_latency", n, 32'd11);
      wait_n = 0;
      @(negedge clk);
      chk("x3_lw", dut.u_rf.regs_q[3], 32'hFFFF_FFFE);

      wait_retire("blt_retire", 20, n);
      @(negedge clk);
      chk("blt_taken_pc", pc, 32'h18);
      wait_retire("bltu_retire", 20, n);
      @(negedge clk);
      chk("bltu_not_taken_pc", pc, 32'h1C);
      wait_retire("addi_x0_retire", 20, n);
      wait_retire("jal_retire", 20, n);
      @(negedge clk);
      chk("jal_pc", pc, 32'h30);
      chk("jal_link", dut.u_rf.regs_q[5], 32'h24);
      wait_retire("lui_retire", 20, n);
      @(negedge clk);
      chk("lui_x6", dut.u_rf.regs_q[6], 32'hABCDE000);
      chk("x0_zero", dut.u_rf.regs_q[0], 32'd0);
      chk("skipped_x7", dut.u_rf.regs_q[7], 32'd0);

      r0 = ret_cnt;
      wait_halt("illegal_halt", 20);
      repeat (10) @(negedge clk);
      chk("illegal_sticky", {31'b0, halted}, 32'd1);
      chk("illegal_req", {31'b0, mif.mem_req}, 32'd0);
      chk("illegal_no_retire", ret_cnt, r0);
      chk("illegal_pc", pc, 32'h34);

      prog[0] = 32'h00000073;  // ecall
      do_reset();
      r0 = ret_cnt;
      wait_halt("ecall_halt", 20);
      repeat (5) @(negedge clk);
      chk("ecall_req", {31'b0, mif.mem_req}, 32'd0);
      chk("ecall_no_retire", ret_cnt, r0);

      prog[0] = 32'h00200067;  // jalr x0,2(x0)
      do_reset();
      r0 = ret_cnt;
      wait_halt("jalr_halt", 20);
      repeat (5) @(negedge clk);
      chk("jalr_pc_kept", pc, 32'd0);
      chk("jalr_no_retire", ret_cnt, r0);

      prog[0] = 32'h00500093;  // addi x1,x0,5
      prog[1] = 32'h04102223;  // sw   x1,0x44(x0)
      wait_n  = 5;
      do_reset();
      wait_retire("pre_sw_retire", 20, n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(mif.mem_req && mif.mem_we) && n < 40);
      chk("sw_in_mem", {31'b0, mif.mem_req & mif.mem_we}, 32'd1);
      rst = 1'b0;
      #1;
      chk("midmem_req_drop", {31'b0, mif.mem_req}, 32'd0);
      chk("midmem_pc", pc, 32'd0);
      chk("midmem_x1_clear", dut.u_rf.regs_q[1], 32'd0);
      chk("midmem_no_store", dmem[1], 32'd0);
      wait_n = 0;
      @(negedge clk);
      rst = 1'b1;
      stale_ack = 1'b1;
      @(posedge clk);
      #1 stale_ack = 1'b0;
      @(negedge clk);
      chk("restart_req", {31'b0, mif.mem_req}, 32'd1);
      chk("restart_addr", mif.mem_addr, 32'd0);
      wait_retire("restart_retire", 20, n);
      @(negedge clk);
      chk("restart_x1", dut.u_rf.regs_q[1], 32'd5);

      chk("nregs16_halt", {31'b0, halted16}, 32'd1);
      chk("nregs16_no_retire", ret16_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
Parametrised multi-cycle RV32I-subset core, successor to the single-cycle top-level cpu.
- Fetch, decode, execute, memory and writeback are sequenced by an FSM, not done in one cycle.
- Instruction fetch and data access share one memory port with a req/ack handshake, so memory may take any number of wait cycles.
- Register file, ALU, branch compare and immediate generation are internal.
- Halts cleanly on illegal instruction, misaligned target, ECALL or EBREAK.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.
- NREGS, 32, architectural register count; legal values are 16 (RV32E) and 32.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  1 = store, 0 = fetch or load.
- mem_addr  out  XLEN  word address; bits [1:0] always 0.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  request completes this cycle.
- pc_o  out  XLEN  current PC.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky; set on HALT entry.

Behaviour:
- Reset (async assert, any state):
  - state=FETCH, pc=RESET_PC, every register =0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0.
  - An in-flight request is abandoned; an ack arriving after reset release is ignored.
  - Release is synchronous to clk.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, OP-IMM (all 9), OP (all 10).
  - Anything else is illegal.
  - Byte and halfword loads/stores are illegal.
- FSM:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack, ir<=mem_rdata and go to DECODE.
  - DECODE: read rs1/rs2 and build the immediate.
    - Illegal opcode/funct, or any rs1/rs2/rd index >= NREGS → HALT.
    - ECALL/EBREAK (SYSTEM opcode) → HALT.
    - Otherwise → EXEC.
  - EXEC: compute ALU result, branch decision and next_pc.
    - Branch/JAL/JALR target with bit1 set → HALT; pc is not updated.
    - JALR clears target bit0 before the check.
    - LW/SW → MEM; all others → WB.
  - MEM: mem_req=1, mem_addr={alu[XLEN-1:2],2'b00}, mem_we=(SW), mem_wdata=rs2.
    - alu[1:0]≠0 → HALT, with no request issued.
    - On mem_ack: for LW, latch mem_rdata; go to WB.
  - WB: write rd if rd≠0 and the instruction writes a register.
    - Writeback source: loaded data for LW, pc+4 for JAL/JALR, ALU result otherwise.
    - pc<=next_pc; retire=1 for exactly this cycle; → FETCH.
  - HALT: terminal. halted=1, mem_req=0. Only rst exits.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and ack has not arrived.
  - mem_req drops in the cycle after the ack cycle.
  - Ack while mem_req=0 is ignored.
  - Zero wait states: mem_ack is high in the first req cycle.
- Latency with zero wait states: ALU/branch/jump = 4 cycles; LW/SW = 5 cycles. Each wait cycle adds 1.
- Arithmetic:
  - Add/sub wrap modulo 2^XLEN.
  - Shift amount is the low 5 bits.
  - SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
  - SRA sign-fills.
- x0 reads 0 in all cases; a write to x0 is discarded.
- next_pc:
  - Taken branch or JAL: pc+imm.
  - JALR: (rs1+imm)&~1.
  - Otherwise: pc+4.
  - All wrap modulo 2^XLEN.

Decomposition:
- cpu_pkg holds:
  - opcode constants: OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM.
  - state_t enum: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - alu_op_t enum.
  - imm_t enum: I, S, B, U, J.
  - wb_sel_t enum: ALU, MEM, PC4.
- One sub-module, cpu_mc_regfile: NREGS×XLEN, 2 combinational read ports, 1 synchronous write port, x0 hardwired, async active-low clear.

Test Plan:
- `addi x1,x0,5; addi x2,x1,-7` with ack every request's first cycle → x2=32'hFFFF_FFFE; retire pulses exactly every 4 cycles; pc_o=8.
- `sw x2,0x40(x0); lw x3,0x40(x0)` with 3 ack wait cycles each → mem_addr=0x40 held stable 4 cycles with mem_we=1, then x3=32'hFFFF_FFFE; LW retires 5+3+3=11 cycles after its fetch starts.
- `blt x2,x1,+8` (x2=-2, x1=5) → pc advances by 8. `bltu x2,x1,+8` → not taken, pc+4. `jal x5,+16` at pc=0x20 → x5=0x24, pc=0x30.
- `addi x0,x0,1` then `lui x6,0xABCDE` → x0 still 0; x6=32'hABCDE000.
- Opcode 7'b0000000, then separately `ecall`, then separately `jalr x0,2(x0)` → HALT; halted=1 stays set; mem_req=0; no further retire.
- rst asserted mid-MEM with mem_req=1 → mem_req drops combinationally; pc=RESET_PC; registers cleared; a stale ack after release is ignored; fetch restarts from RESET_PC. With NREGS=16, `addi x20,x0,1` → HALT.
